// File: rtl/uart_pkg.sv
// Shared types for the UART loopback buffer: FSM state encodings and default character width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_WAIT = 1'b1
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_REQ  = 2'd1,
    T_BUSY = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_W-1:0]     i_push_data,
  input  logic                  i_pop,
  output logic [DATA_W-1:0]     o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  logic [DATA_W-1:0]   r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_head  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is then legal.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/uart_loopback_buf.sv
// Buffered glue between uart_rx and uart_tx: loop mode drains the FIFO to TX, host mode exposes both sides.
// Optional macro UART_LB_OVERRUN_EN: drop-and-flag on a full FIFO instead of backpressuring uart_rx.
module uart_loopback_buf
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_data_available,
  output logic                  rx_clear,
  input  logic                  tx_idle,
  output logic                  tx_request,
  output logic [DATA_W-1:0]     tx_data,
  input  logic                  loop_en,
  output logic                  host_rd_valid,
  output logic [DATA_W-1:0]     host_rd_data,
  input  logic                  host_rd_ready,
  input  logic                  host_wr_valid,
  input  logic [DATA_W-1:0]     host_wr_data,
  output logic                  host_wr_ready,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  rx_state_e         r_rx_state;
  tx_state_e         r_tx_state;
  logic              r_rx_clear;
  logic              r_tx_request;
  logic [DATA_W-1:0] r_tx_data;

  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic              w_pop;
  logic              w_rx_take;
  logic              w_rx_drop;
  logic              w_loop_take;
  logic              w_host_take;
  logic              w_host_pop;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_rx_take),
    .i_push_data (rx_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (fifo_count)
  );

  assign w_rx_take = (r_rx_state == R_IDLE) && rx_data_available && !w_full;

`ifdef UART_LB_OVERRUN_EN
  logic r_overrun;

  assign w_rx_drop = (r_rx_state == R_IDLE) && rx_data_available && w_full;
  assign overrun   = r_overrun;

  // Set wins over a simultaneous clear so no drop goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_overrun <= 1'b0;
    else if (w_rx_drop)   r_overrun <= 1'b1;
    else if (overrun_clr) r_overrun <= 1'b0;
  end
`else
  logic w_unused_overrun_clr;

  assign w_rx_drop            = 1'b0;
  assign overrun              = 1'b0;
  assign w_unused_overrun_clr = overrun_clr;
`endif

  // R_WAIT holds off a second capture until uart_rx has seen the clear and dropped its level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= R_IDLE;
      r_rx_clear <= 1'b0;
    end else begin
      r_rx_clear <= w_rx_take || w_rx_drop;
      case (r_rx_state)
        R_IDLE: if (w_rx_take || w_rx_drop) r_rx_state <= R_WAIT;
        R_WAIT: if (!rx_data_available)     r_rx_state <= R_IDLE;
      endcase
    end
  end

  assign rx_clear = r_rx_clear;

  assign host_wr_ready = (r_tx_state == T_IDLE) && tx_idle && !loop_en;
  assign w_host_take   = host_wr_ready && host_wr_valid;
  assign w_loop_take   = (r_tx_state == T_IDLE) && tx_idle && loop_en && !w_empty;
  assign host_rd_valid = !w_empty && !loop_en;
  assign host_rd_data  = w_head;
  assign w_host_pop    = host_rd_valid && host_rd_ready;
  assign w_pop         = w_loop_take || w_host_pop;

  // loop_en only matters in T_IDLE, so a mode change never interrupts a byte in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state   <= T_IDLE;
      r_tx_request <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      case (r_tx_state)
        T_IDLE: begin
          if (w_loop_take) begin
            r_tx_data    <= w_head;
            r_tx_request <= 1'b1;
            r_tx_state   <= T_REQ;
          end else if (w_host_take) begin
            r_tx_data    <= host_wr_data;
            r_tx_request <= 1'b1;
            r_tx_state   <= T_REQ;
          end
        end
        T_REQ: begin
          if (!tx_idle) begin
            r_tx_request <= 1'b0;
            r_tx_state   <= T_BUSY;
          end
        end
        T_BUSY: begin
          if (tx_idle) r_tx_state <= T_IDLE;
        end
        default: begin
          r_tx_request <= 1'b0;
          r_tx_state   <= T_IDLE;
        end
      endcase
    end
  end

  assign tx_request = r_tx_request;
  assign tx_data    = r_tx_data;

endmodule

// File: tb/tb_uart_loopback_buf.sv
// Scoreboard bench for uart_loopback_buf with uart_rx/uart_tx behavioural models.
module tb_uart_loopback_buf;
  localparam int DATA_W     = 8;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [DATA_W-1:0]   rx_data;
  logic                rx_data_available;
  logic                rx_clear;
  logic                tx_idle;
  logic                tx_request;
  logic [DATA_W-1:0]   tx_data;
  logic                loop_en;
  logic                host_rd_valid;
  logic [DATA_W-1:0]   host_rd_data;
  logic                host_rd_ready;
  logic                host_wr_valid;
  logic [DATA_W-1:0]   host_wr_data;
  logic                host_wr_ready;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                overrun;
  logic                overrun_clr;

  always #5 clk = ~clk;

  uart_loopback_buf #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_data_available(rx_data_available), .rx_clear(rx_clear),
    .tx_idle(tx_idle), .tx_request(tx_request), .tx_data(tx_data),
    .loop_en(loop_en),
    .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data), .host_rd_ready(host_rd_ready),
    .host_wr_valid(host_wr_valid), .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
    .fifo_count(fifo_count), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] txq[$];
  logic [7:0] hq[$];
  int clr_cnt = 0;
  int wr_acc  = 0;
  bit stable_err  = 0;
  bit pulse_err   = 0;
  bit wr_loop_err = 0;
  bit rdv_loop_err = 0;
  bit tx_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  // Monitor: samples 3ns after the falling edge, after stimulus and well clear of the rising edge.
  initial begin
    logic       prev_req;
    logic       prev_clr;
    logic [7:0] cap;
    prev_req = 1'b0; prev_clr = 1'b0; cap = '0;
    forever begin
      @(negedge clk); #3;
      if (tx_request && !prev_req) begin
        if (txq.size() == 0) fail_now("tx_spurious_request");
        else chk("tx_data", tx_data, txq.pop_front());
        cap = tx_data;
      end else if (tx_request && tx_data !== cap) begin
        stable_err = 1;
      end
      prev_req = tx_request;
      if (rx_clear) begin
        clr_cnt++;
        if (prev_clr) pulse_err = 1;
      end
      prev_clr = rx_clear;
      if (host_rd_valid && host_rd_ready) begin
        if (hq.size() == 0) fail_now("host_rd_spurious");
        else chk("host_rd_data", host_rd_data, hq.pop_front());
      end
      if (host_wr_valid && host_wr_ready) wr_acc++;
      if (loop_en && host_wr_ready) wr_loop_err = 1;
      if (loop_en && host_rd_valid) rdv_loop_err = 1;
    end
  end

  // uart_tx model: takes a request, goes busy for a random frame time, then idles again.
  initial begin
    tx_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_request && !tx_stall) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        tx_idle = 1'b0;
        repeat ($urandom_range(2, 8)) @(negedge clk);
        tx_idle = 1'b1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_clear(output bit ok);
    ok = 0;
    repeat (500) begin
      @(negedge clk);
      if (rx_clear) begin ok = 1; break; end
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input int hold);
    bit ok;
    rx_data = b;
    rx_data_available = 1'b1;
    wait_clear(ok);
    if (!ok) fail_now("rx_clear_timeout");
    repeat (hold) @(negedge clk);
    rx_data_available = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_room();
    bit ok;
    ok = 0;
    repeat (500) begin
      if (fifo_count < DEPTH) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) fail_now("fifo_room_timeout");
  endtask

  task automatic host_write(input logic [7:0] b);
    int a0;
    bit ok;
    txq.push_back(b);
    a0 = wr_acc;
    host_wr_data  = b;
    host_wr_valid = 1'b1;
    ok = 0;
    repeat (500) begin
      @(negedge clk);
      if (wr_acc != a0) begin ok = 1; break; end
    end
    host_wr_valid = 1'b0;
    if (!ok) fail_now("host_wr_timeout");
  endtask

  task automatic wait_tx_drain();
    bit ok;
    ok = 0;
    repeat (2000) begin
      @(negedge clk);
      if (txq.size() == 0 && tx_idle && !tx_request) begin ok = 1; break; end
    end
    if (!ok) fail_now("tx_drain_timeout");
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int c0;
    bit ok;
    logic [7:0] b;

    rst_n = 1'b0;
    rx_data = '0; rx_data_available = 1'b0;
    loop_en = 1'b1;
    host_rd_ready = 1'b0; host_wr_valid = 1'b0; host_wr_data = '0;
    overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_clear", rx_clear, 0);
    chk("rst_tx_request", tx_request, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loop mode: fixed bytes then random bytes, each expected on TX in order.
    for (int i = 0; i < 12; i++) begin
      b = (i == 0) ? 8'h55 : (i == 1) ? 8'hA3 : 8'($urandom);
      wait_room();
      txq.push_back(b);
      c0 = clr_cnt;
      send_rx(b, $urandom_range(0, 3));
      chk("loop_clear_pulses", clr_cnt - c0, 1);
    end
    wait_tx_drain();
    chk("loop_count_zero", fifo_count, 0);

    // Host mode: one capture despite a long-held level, then fill to full.
    loop_en = 1'b0;
    @(negedge clk);
    c0 = clr_cnt;
    hq.push_back(8'h01);
    send_rx(8'h01, 20);
    chk("held_level_clears", clr_cnt - c0, 1);
    chk("held_level_count", fifo_count, 1);
    for (int i = 2; i <= 4; i++) begin
      hq.push_back(8'(i));
      send_rx(8'(i), 0);
    end
    chk("full_count", fifo_count, 4);
    chk("full_rd_valid", host_rd_valid, 1);
    chk("full_head", host_rd_data, 8'h01);

    c0 = clr_cnt;
    rx_data = 8'h05;
    rx_data_available = 1'b1;
    repeat (10) @(negedge clk);
`ifdef UART_LB_OVERRUN_EN
    chk("ovr_clear_pulses", clr_cnt - c0, 1);
    chk("ovr_flag_set", overrun, 1);
    chk("ovr_count", fifo_count, 4);
    rx_data_available = 1'b0;
    repeat (5) @(negedge clk);
    chk("ovr_flag_sticky", overrun, 1);
    host_rd_ready = 1'b1;
    @(negedge clk);
    host_rd_ready = 1'b0;
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    @(negedge clk);
    chk("ovr_flag_cleared", overrun, 0);
    chk("ovr_count_after_pop", fifo_count, 3);
`else
    chk("bp_no_clear", clr_cnt - c0, 0);
    chk("bp_count", fifo_count, 4);
    chk("bp_overrun_zero", overrun, 0);
    hq.push_back(8'h05);
    host_rd_ready = 1'b1;
    @(negedge clk);
    host_rd_ready = 1'b0;
    wait_clear(ok);
    if (!ok) fail_now("bp_accept_timeout");
    rx_data_available = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp_count_after_accept", fifo_count, 4);
`endif
    host_rd_ready = 1'b1;
    ok = 0;
    repeat (50) begin
      @(negedge clk);
      if (!host_rd_valid) begin ok = 1; break; end
    end
    host_rd_ready = 1'b0;
    if (!ok) fail_now("host_drain_timeout");
    chk("host_drain_count", fifo_count, 0);
    chk("host_queue_empty", hq.size(), 0);

    // Host write, then switch to loop mode mid-frame: FIFO bytes follow the host byte.
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      send_rx(b, 0);
      hq.push_back(b);
    end
    host_write(8'h7E);
    while (hq.size() != 0) txq.push_back(hq.pop_front());
    ok = 0;
    repeat (100) begin
      @(negedge clk);
      if (!tx_idle) begin ok = 1; break; end
    end
    if (!ok) fail_now("tx_busy_timeout");
    loop_en = 1'b1;
    wait_tx_drain();
    chk("mode_switch_count", fifo_count, 0);

    loop_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) host_write(8'($urandom));
    wait_tx_drain();

    // Reset while a request is pending and an rx clear is being issued.
    loop_en = 1'b1;
    tx_stall = 1'b1;
    b = 8'($urandom);
    txq.push_back(b);
    send_rx(b, 0);
    ok = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_request) begin ok = 1; break; end
    end
    if (!ok) fail_now("tx_request_timeout");
    rx_data = 8'($urandom);
    rx_data_available = 1'b1;
    wait_clear(ok);
    if (!ok) fail_now("rx_clear_timeout_rst");
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tx_request", tx_request, 0);
    chk("arst_rx_clear", rx_clear, 0);
    chk("arst_fifo_count", fifo_count, 0);
    chk("arst_tx_data", tx_data, 0);
    rx_data_available = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tx_stall = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_no_request", tx_request, 0);
    chk("post_rst_count", fifo_count, 0);

    chk("tx_queue_empty", txq.size(), 0);
    chk("tx_data_stable", stable_err, 0);
    chk("rx_clear_single_cycle", pulse_err, 0);
    chk("no_wr_ready_in_loop", wr_loop_err, 0);
    chk("no_rd_valid_in_loop", rdv_loop_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
